// File: rtl/msrh_lsu_pkg.sv
// Shared LSU types and constants for the L1D load-request queue (LRQ).
package msrh_lsu_pkg;

    localparam int LSU_PIPE_NUM    = 2;
    localparam int LRQ_ENTRY_SIZE  = 4;
    localparam int LRQ_TAG_W       = $clog2(LRQ_ENTRY_SIZE);
    localparam int PADDR_W         = 40;
    localparam int DCACHE_DATA_B_W = 64;
    localparam int DCACHE_DATA_W   = DCACHE_DATA_B_W * 8;
    localparam int LINE_OFS_W      = $clog2(DCACHE_DATA_B_W);

    typedef enum logic [1:0] {
        IDLE,
        READY,
        WAIT_RESP,
        FILL
    } lrq_state_t;

    typedef struct packed {
        lrq_state_t         state;
        logic [PADDR_W-1:0] paddr;
    } lrq_entry_t;

    typedef struct packed {
        logic [PADDR_W-1:0]   paddr;
        logic [LRQ_TAG_W-1:0] tag;
    } l2_req_t;

    typedef struct packed {
        logic [LRQ_TAG_W-1:0]     tag;
        logic [DCACHE_DATA_W-1:0] data;
    } l2_resp_t;

    // Clear the byte-within-line bits so only the line address remains.
    function automatic logic [PADDR_W-1:0] line_align(input logic [PADDR_W-1:0] paddr);
        return {paddr[PADDR_W-1:LINE_OFS_W], {LINE_OFS_W{1'b0}}};
    endfunction

    // Add with saturation at all-ones.
    function automatic logic [31:0] sat_add32(input logic [31:0] cnt, input logic [31:0] inc);
        logic [32:0] sum;
        sum = {1'b0, cnt} + {1'b0, inc};
        return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
    endfunction

endpackage

// File: rtl/msrh_lrq_entry.sv
// One LRQ refill entry: lifecycle state, line address and per-pipe line match.
module msrh_lrq_entry
    import msrh_lsu_pkg::*;
#(
    parameter int PIPE_NUM = LSU_PIPE_NUM
) (
    input  logic                              i_clk,
    input  logic                              i_reset_n,
    input  logic                              i_alloc,
    input  logic [PADDR_W-1:0]                i_alloc_paddr,
    input  logic                              i_req_accept,
    input  logic                              i_resp_hit,
    input  logic                              i_fill_done,
    input  logic [PIPE_NUM-1:0][PADDR_W-1:0]  i_cmp_paddr,
    output logic [PIPE_NUM-1:0]               o_match,
    output lrq_entry_t                        o_entry
);

    lrq_state_t         state;
    lrq_state_t         state_next;
    logic [PADDR_W-1:0] paddr;

    // State register and captured line address.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state <= IDLE;
            paddr <= '0;
        end else begin
            state <= state_next;
            if (i_alloc) begin
                paddr <= i_alloc_paddr;
            end
        end
    end

    // Next-state logic for the entry lifecycle.
    // NOTE: state_next is defaulted first so no path through the case infers a latch.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:      if (i_alloc)      state_next = READY;
            READY:     if (i_req_accept) state_next = WAIT_RESP;
            WAIT_RESP: if (i_resp_hit)   state_next = FILL;
            FILL:      if (i_fill_done)  state_next = IDLE;
            default:                     state_next = IDLE;
        endcase
    end

    // A busy entry (FILL included) matches any request to the same line.
    always_comb begin
        o_match = '0;
        for (int p = 0; p < PIPE_NUM; p++) begin
            o_match[p] = (state != IDLE) && (paddr == i_cmp_paddr[p]);
        end
    end

    assign o_entry.state = state;
    assign o_entry.paddr = paddr;

endmodule

// File: rtl/msrh_l1d_lrq.sv
// L1D load-request queue: allocates refill entries for LSU misses, issues
// refills to L2, writes returned lines into L1D and broadcasts resolves.
// Optional build macro MSRH_LRQ_PERF_COUNTER_EN adds saturating perf counters.
module msrh_l1d_lrq
    import msrh_lsu_pkg::*;
#(
    parameter int LSU_PIPE_NUM   = msrh_lsu_pkg::LSU_PIPE_NUM,
    parameter int LRQ_ENTRY_SIZE = msrh_lsu_pkg::LRQ_ENTRY_SIZE
) (
    input  logic                                         i_clk,
    input  logic                                         i_reset_n,
`ifdef MSRH_LRQ_PERF_COUNTER_EN
    output logic [31:0]                                  o_perf_alloc_cnt,
    output logic [31:0]                                  o_perf_conflict_cnt,
    output logic [31:0]                                  o_perf_full_cnt,
`endif
    input  logic [LSU_PIPE_NUM-1:0]                      i_lrq_load,
    input  logic [LSU_PIPE_NUM-1:0][PADDR_W-1:0]         i_lrq_paddr,
    output logic [LSU_PIPE_NUM-1:0]                      o_lrq_conflict,
    output logic [LSU_PIPE_NUM-1:0]                      o_lrq_full,
    output logic [LSU_PIPE_NUM-1:0][LRQ_ENTRY_SIZE-1:0]  o_lrq_index_oh,
    output logic                                         o_l2_req_valid,
    input  logic                                         i_l2_req_ready,
    output logic [PADDR_W-1:0]                           o_l2_req_paddr,
    output logic [$clog2(LRQ_ENTRY_SIZE)-1:0]            o_l2_req_tag,
    input  logic                                         i_l2_resp_valid,
    input  logic [$clog2(LRQ_ENTRY_SIZE)-1:0]            i_l2_resp_tag,
    input  logic [DCACHE_DATA_W-1:0]                     i_l2_resp_data,
    output logic                                         o_l1d_wr_valid,
    output logic [PADDR_W-1:0]                           o_l1d_wr_paddr,
    output logic [DCACHE_DATA_W-1:0]                     o_l1d_wr_data,
    output logic                                         o_lrq_resolve_valid,
    output logic [LRQ_ENTRY_SIZE-1:0]                    o_lrq_resolve_index_oh
);

    localparam int TAG_W = $clog2(LRQ_ENTRY_SIZE);

    logic [LSU_PIPE_NUM-1:0][PADDR_W-1:0]        req_line;
    lrq_entry_t                                  entries   [LRQ_ENTRY_SIZE];
    logic [LSU_PIPE_NUM-1:0]                     entry_match [LRQ_ENTRY_SIZE];
    logic [LRQ_ENTRY_SIZE-1:0]                   idle_vec;
    logic [LRQ_ENTRY_SIZE-1:0]                   ready_vec;

    logic [LRQ_ENTRY_SIZE-1:0]                   alloc_en;
    logic [LRQ_ENTRY_SIZE-1:0][PADDR_W-1:0]      alloc_paddr;
    logic [LRQ_ENTRY_SIZE-1:0]                   taken;
    logic [LRQ_ENTRY_SIZE-1:0]                   hit_oh;
    logic [LRQ_ENTRY_SIZE-1:0]                   free_vec;
    logic [LRQ_ENTRY_SIZE-1:0]                   pick_oh;
    logic                                        pipe_hit;

    logic                                        req_hold;
    logic [TAG_W-1:0]                            req_hold_idx;
    logic [TAG_W-1:0]                            req_sel;
    logic                                        req_valid;
    logic                                        req_fire;

    logic                                        resp_hit;
    logic                                        fill_valid;
    logic [TAG_W-1:0]                            fill_tag;
    logic [DCACHE_DATA_W-1:0]                    fill_data;

    always_comb begin
        for (int p = 0; p < LSU_PIPE_NUM; p++) begin
            req_line[p] = line_align(i_lrq_paddr[p]);
        end
    end

    // Entry array.
    for (genvar e = 0; e < LRQ_ENTRY_SIZE; e++) begin : g_entry
        msrh_lrq_entry #(.PIPE_NUM(LSU_PIPE_NUM)) u_entry (
            .i_clk         (i_clk),
            .i_reset_n     (i_reset_n),
            .i_alloc       (alloc_en[e]),
            .i_alloc_paddr (alloc_paddr[e]),
            .i_req_accept  (req_fire && (req_sel == TAG_W'(e))),
            .i_resp_hit    (resp_hit && (i_l2_resp_tag == TAG_W'(e))),
            .i_fill_done   (fill_valid && (fill_tag == TAG_W'(e))),
            .i_cmp_paddr   (req_line),
            .o_match       (entry_match[e]),
            .o_entry       (entries[e])
        );
        assign idle_vec[e]  = (entries[e].state == IDLE);
        assign ready_vec[e] = (entries[e].state == READY);
    end

    // Per-pipe request resolution in pipe order: entry conflict, then
    // lower-pipe conflict, then lowest free entry, else full.
    always_comb begin
        o_lrq_conflict = '0;
        o_lrq_full     = '0;
        o_lrq_index_oh = '0;
        alloc_en       = '0;
        alloc_paddr    = '0;
        taken          = '0;
        hit_oh         = '0;
        free_vec       = '0;
        pick_oh        = '0;
        pipe_hit       = 1'b0;
        for (int p = 0; p < LSU_PIPE_NUM; p++) begin
            if (i_lrq_load[p]) begin
                hit_oh   = '0;
                pipe_hit = 1'b0;
                for (int e = 0; e < LRQ_ENTRY_SIZE; e++) begin
                    hit_oh[e] = entry_match[e][p];
                end
                if (hit_oh == '0) begin
                    for (int q = 0; q < LSU_PIPE_NUM; q++) begin
                        if (q < p && !pipe_hit && i_lrq_load[q] && !o_lrq_full[q] &&
                            (req_line[q] == req_line[p])) begin
                            hit_oh   = o_lrq_index_oh[q];
                            pipe_hit = 1'b1;
                        end
                    end
                end
                if (hit_oh != '0) begin
                    o_lrq_conflict[p] = 1'b1;
                    o_lrq_index_oh[p] = hit_oh;
                end else begin
                    free_vec = idle_vec & ~taken;
                    pick_oh  = free_vec & (~free_vec + 1'b1);
                    if (pick_oh != '0) begin
                        taken             = taken | pick_oh;
                        alloc_en          = alloc_en | pick_oh;
                        o_lrq_index_oh[p] = pick_oh;
                        for (int e = 0; e < LRQ_ENTRY_SIZE; e++) begin
                            if (pick_oh[e]) begin
                                alloc_paddr[e] = req_line[p];
                            end
                        end
                    end else begin
                        o_lrq_full[p] = 1'b1;
                    end
                end
            end
        end
    end

    // L2 request select: lowest READY entry unless a stalled request is held.
    always_comb begin
        req_valid = 1'b0;
        req_sel   = '0;
        if (req_hold) begin
            req_valid = 1'b1;
            req_sel   = req_hold_idx;
        end else begin
            for (int e = LRQ_ENTRY_SIZE - 1; e >= 0; e--) begin
                if (ready_vec[e]) begin
                    req_valid = 1'b1;
                    req_sel   = TAG_W'(e);
                end
            end
        end
    end

    assign req_fire       = req_valid && i_l2_req_ready;
    assign o_l2_req_valid = req_valid;
    assign o_l2_req_tag   = req_sel;
    assign o_l2_req_paddr = req_valid ? entries[req_sel].paddr : '0;

    // Remember a stalled request so a newly READY lower entry cannot displace it.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            req_hold     <= 1'b0;
            req_hold_idx <= '0;
        end else begin
            req_hold     <= req_valid && !i_l2_req_ready;
            req_hold_idx <= req_sel;
        end
    end

    assign resp_hit = i_l2_resp_valid && (entries[i_l2_resp_tag].state == WAIT_RESP);

    // Single fill register: captures a valid response for one cycle of write-out.
    // NOTE: the wide data register is reset too, so outputs read zero straight out of reset.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            fill_valid <= 1'b0;
            fill_tag   <= '0;
            fill_data  <= '0;
        end else begin
            fill_valid <= resp_hit;
            if (resp_hit) begin
                fill_tag  <= i_l2_resp_tag;
                fill_data <= i_l2_resp_data;
            end
        end
    end

    assign o_l1d_wr_valid         = fill_valid;
    assign o_l1d_wr_paddr         = fill_valid ? entries[fill_tag].paddr : '0;
    assign o_l1d_wr_data          = fill_valid ? fill_data : '0;
    assign o_lrq_resolve_valid    = fill_valid;
    assign o_lrq_resolve_index_oh = fill_valid ? (LRQ_ENTRY_SIZE'(1) << fill_tag) : '0;

    // Flag L2 responses whose tag does not name an entry waiting on L2.
    always_ff @(posedge i_clk) begin
        if (i_reset_n && i_l2_resp_valid) begin
            assert (entries[i_l2_resp_tag].state == WAIT_RESP)
            else $warning("LRQ orphan L2 response, tag %0d", i_l2_resp_tag);
        end
    end

`ifdef MSRH_LRQ_PERF_COUNTER_EN
    logic [31:0] alloc_num;
    logic [31:0] conflict_num;
    logic [31:0] full_num;

    // Per-cycle event counts across all pipes.
    always_comb begin
        alloc_num    = '0;
        conflict_num = '0;
        full_num     = '0;
        for (int p = 0; p < LSU_PIPE_NUM; p++) begin
            alloc_num    = alloc_num    + 32'(i_lrq_load[p] && !o_lrq_conflict[p] && !o_lrq_full[p]);
            conflict_num = conflict_num + 32'(o_lrq_conflict[p]);
            full_num     = full_num     + 32'(o_lrq_full[p]);
        end
    end

    // Saturating performance counters.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_perf_alloc_cnt    <= '0;
            o_perf_conflict_cnt <= '0;
            o_perf_full_cnt     <= '0;
        end else begin
            o_perf_alloc_cnt    <= sat_add32(o_perf_alloc_cnt, alloc_num);
            o_perf_conflict_cnt <= sat_add32(o_perf_conflict_cnt, conflict_num);
            o_perf_full_cnt     <= sat_add32(o_perf_full_cnt, full_num);
        end
    end
`endif

endmodule

// File: tb/tb_msrh_l1d_lrq.sv
// Directed self-checking bench for msrh_l1d_lrq.
module tb_msrh_l1d_lrq;
    import msrh_lsu_pkg::*;

    logic                                       i_clk;
    logic                                       i_reset_n;
    logic [LSU_PIPE_NUM-1:0]                    i_lrq_load;
    logic [LSU_PIPE_NUM-1:0][PADDR_W-1:0]       i_lrq_paddr;
    logic [LSU_PIPE_NUM-1:0]                    o_lrq_conflict;
    logic [LSU_PIPE_NUM-1:0]                    o_lrq_full;
    logic [LSU_PIPE_NUM-1:0][LRQ_ENTRY_SIZE-1:0] o_lrq_index_oh;
    logic                                       o_l2_req_valid;
    logic                                       i_l2_req_ready;
    logic [PADDR_W-1:0]                         o_l2_req_paddr;
    logic [LRQ_TAG_W-1:0]                       o_l2_req_tag;
    logic                                       i_l2_resp_valid;
    logic [LRQ_TAG_W-1:0]                       i_l2_resp_tag;
    logic [DCACHE_DATA_W-1:0]                   i_l2_resp_data;
    logic                                       o_l1d_wr_valid;
    logic [PADDR_W-1:0]                         o_l1d_wr_paddr;
    logic [DCACHE_DATA_W-1:0]                   o_l1d_wr_data;
    logic                                       o_lrq_resolve_valid;
    logic [LRQ_ENTRY_SIZE-1:0]                  o_lrq_resolve_index_oh;
`ifdef MSRH_LRQ_PERF_COUNTER_EN
    logic [31:0] o_perf_alloc_cnt;
    logic [31:0] o_perf_conflict_cnt;
    logic [31:0] o_perf_full_cnt;
`endif

    int n_tests;
    int n_fail;

    msrh_l1d_lrq dut (
        .i_clk                  (i_clk),
        .i_reset_n              (i_reset_n),
`ifdef MSRH_LRQ_PERF_COUNTER_EN
        .o_perf_alloc_cnt       (o_perf_alloc_cnt),
        .o_perf_conflict_cnt    (o_perf_conflict_cnt),
        .o_perf_full_cnt        (o_perf_full_cnt),
`endif
        .i_lrq_load             (i_lrq_load),
        .i_lrq_paddr            (i_lrq_paddr),
        .o_lrq_conflict         (o_lrq_conflict),
        .o_lrq_full             (o_lrq_full),
        .o_lrq_index_oh         (o_lrq_index_oh),
        .o_l2_req_valid         (o_l2_req_valid),
        .i_l2_req_ready         (i_l2_req_ready),
        .o_l2_req_paddr         (o_l2_req_paddr),
        .o_l2_req_tag           (o_l2_req_tag),
        .i_l2_resp_valid        (i_l2_resp_valid),
        .i_l2_resp_tag          (i_l2_resp_tag),
        .i_l2_resp_data         (i_l2_resp_data),
        .o_l1d_wr_valid         (o_l1d_wr_valid),
        .o_l1d_wr_paddr         (o_l1d_wr_paddr),
        .o_l1d_wr_data          (o_l1d_wr_data),
        .o_lrq_resolve_valid    (o_lrq_resolve_valid),
        .o_lrq_resolve_index_oh (o_lrq_resolve_index_oh)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [DCACHE_DATA_W-1:0] got,
                         input logic [DCACHE_DATA_W-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic set_load(input logic v0, input logic [PADDR_W-1:0] a0,
                            input logic v1, input logic [PADDR_W-1:0] a1);
        i_lrq_load     = {v1, v0};
        i_lrq_paddr[0] = a0;
        i_lrq_paddr[1] = a1;
        #1;
    endtask

    task automatic do_reset();
        i_reset_n = 1'b0;
        repeat (2) @(posedge i_clk);
        #1;
        i_reset_n = 1'b1;
        #1;
    endtask

    task automatic check_pipe(input string tag, input int p, input logic conf,
                              input logic full, input logic [LRQ_ENTRY_SIZE-1:0] oh);
        check({tag, "_conflict"}, o_lrq_conflict[p], conf);
        check({tag, "_full"},     o_lrq_full[p],     full);
        check({tag, "_index"},    o_lrq_index_oh[p], oh);
    endtask

    initial begin
        n_tests         = 0;
        n_fail          = 0;
        i_lrq_load      = '0;
        i_lrq_paddr     = '0;
        i_l2_req_ready  = 1'b0;
        i_l2_resp_valid = 1'b0;
        i_l2_resp_tag   = '0;
        i_l2_resp_data  = '0;
        do_reset();

        // Reset state
        check("rst_l2_valid",  o_l2_req_valid, 0);
        check("rst_l2_paddr",  o_l2_req_paddr, 0);
        check("rst_wr_valid",  o_l1d_wr_valid, 0);
        check("rst_resolve",   o_lrq_resolve_valid, 0);
        check("rst_index",     o_lrq_index_oh, 0);
`ifdef MSRH_LRQ_PERF_COUNTER_EN
        check("rst_perf_alloc", o_perf_alloc_cnt, 0);
`endif

        // Single miss on empty queue; L2 request appears only next cycle
        set_load(1, 40'h00_8000_0048, 0, 0);
        check_pipe("t1_p0", 0, 0, 0, 4'b0001);
        check("t1_l2_same_cycle", o_l2_req_valid, 0);
        tick();
        set_load(0, 0, 0, 0);
        check("t1_l2_valid", o_l2_req_valid, 1);
        check("t1_l2_paddr", o_l2_req_paddr, 40'h00_8000_0040);
        check("t1_l2_tag",   o_l2_req_tag, 0);

        // Same line on both pipes in one cycle
        do_reset();
        set_load(1, 40'h00_8000_0040, 1, 40'h00_8000_0070);
        check_pipe("t2_p0", 0, 0, 0, 4'b0001);
        check_pipe("t2_p1", 1, 1, 0, 4'b0001);
        tick();
        // Only entry 0 is busy: next allocations get entries 1 and 2
        set_load(1, 40'h00_9000_0000, 1, 40'h00_9000_0040);
        check_pipe("t3_p0", 0, 0, 0, 4'b0010);
        check_pipe("t3_p1", 1, 0, 0, 4'b0100);
        tick();
        // Pipe0 takes the last entry, so pipe1 sees full
        set_load(1, 40'h00_9000_0080, 1, 40'h00_A000_0000);
        check_pipe("t3_last_p0", 0, 0, 0, 4'b1000);
        check_pipe("t3_last_p1", 1, 0, 1, 4'b0000);
        tick();
        // Queue full; conflict still wins over full
        set_load(1, 40'h00_A000_0000, 1, 40'h00_9000_0050);
        check_pipe("t3_full_p0", 0, 0, 1, 4'b0000);
        check_pipe("t3_conf_p1", 1, 1, 0, 4'b0100);
        tick();
        set_load(0, 0, 0, 0);

        // L2 backpressure holds entry 0
        for (int c = 0; c < 3; c++) begin
            check("t4_hold_valid", o_l2_req_valid, 1);
            check("t4_hold_paddr", o_l2_req_paddr, 40'h00_8000_0040);
            check("t4_hold_tag",   o_l2_req_tag, 0);
            tick();
        end
        i_l2_req_ready = 1'b1;
        #1;
        check("t4_acc0_tag", o_l2_req_tag, 0);
        tick();
        check("t4_acc1_tag",   o_l2_req_tag, 1);
        check("t4_acc1_paddr", o_l2_req_paddr, 40'h00_9000_0000);
        tick();
        check("t4_acc2_tag",   o_l2_req_tag, 2);
        tick();
        check("t4_acc3_tag",   o_l2_req_tag, 3);
        check("t4_acc3_paddr", o_l2_req_paddr, 40'h00_9000_0080);
        tick();
        i_l2_req_ready = 1'b0;
        #1;
        check("t4_none_valid", o_l2_req_valid, 0);

        // Refill response for entry 1
        i_l2_resp_valid = 1'b1;
        i_l2_resp_tag   = 2'd1;
        i_l2_resp_data  = {64{8'hA5}};
        #1;
        check("t5_wr_early", o_l1d_wr_valid, 0);
        tick();
        i_l2_resp_valid = 1'b0;
        set_load(1, 40'h00_B000_0000, 1, 40'h00_9000_0010);
        check("t5_wr_valid",   o_l1d_wr_valid, 1);
        check("t5_wr_paddr",   o_l1d_wr_paddr, 40'h00_9000_0000);
        check("t5_wr_data",    o_l1d_wr_data, {64{8'hA5}});
        check("t5_res_valid",  o_lrq_resolve_valid, 1);
        check("t5_res_oh",     o_lrq_resolve_index_oh, 4'b0010);
        // Entry in FILL is not yet allocatable, but still conflicts
        check_pipe("t5_fill_p0", 0, 0, 1, 4'b0000);
        check_pipe("t5_fill_p1", 1, 1, 0, 4'b0010);
        tick();
        set_load(1, 40'h00_B000_0000, 0, 0);
        check("t5_wr_done",   o_l1d_wr_valid, 0);
        check("t5_res_done",  o_lrq_resolve_valid, 0);
        check_pipe("t5_realloc", 0, 0, 0, 4'b0010);
        tick();
        set_load(0, 0, 0, 0);

        // Reset while entries 0, 2, 3 wait on L2
        i_reset_n = 1'b0;
        #1;
        check("t6_rst_l2_valid", o_l2_req_valid, 0);
        check("t6_rst_l2_paddr", o_l2_req_paddr, 0);
        check("t6_rst_wr",       o_l1d_wr_valid, 0);
        repeat (2) @(posedge i_clk);
        #1;
        i_reset_n       = 1'b1;
        i_l2_resp_valid = 1'b1;
        i_l2_resp_tag   = 2'd0;
        i_l2_resp_data  = {64{8'h3C}};
        tick();
        i_l2_resp_valid = 1'b0;
        #1;
        check("t6_orphan_wr",      o_l1d_wr_valid, 0);
        check("t6_orphan_resolve", o_lrq_resolve_valid, 0);
        check("t6_orphan_data",    o_l1d_wr_data, 0);
        check("t6_l2_valid",       o_l2_req_valid, 0);
        set_load(1, 40'h00_C000_0000, 0, 0);
        check_pipe("t6_empty", 0, 0, 0, 4'b0001);
        tick();
        set_load(0, 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
